// File: rtl/master_control_pkg.sv
// master_control_pkg: definitions shared by the chip2chip master and slave.
// Holds the FSM state encoding, the link data width and the default timing constants,
// so both boards agree on the handshake timing.
package master_control_pkg;

    localparam int unsigned DATA_W                 = 3;
    localparam int unsigned DEFAULT_DELAY_CYCLES   = 100_000_000; // 1 s at 100 MHz
    localparam int unsigned DEFAULT_VALID_CYCLES   = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 300_000_000; // 3 s at 100 MHz

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StWaitAck = 2'b01,
        StDelay   = 2'b10,
        StSend    = 2'b11
    } state_e;

    // Timer width that can count up to (largest cycle count - 1), at least 1 bit.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/master_control_if.sv
// master_control_if: chip2chip master-side signal bundle.
// Signals:
//   send, data_sw  - from the debounce/one-pulse front end
//   ack            - from the slave receiver
//   request, valid, data_out - to the slave receiver
//   notice, busy, timeout    - status to LEDs / local logic
// Modports: master (the control FSM), slave (the remote receiver side).
interface master_control_if;
    import master_control_pkg::*;

    logic              send;
    logic [DATA_W-1:0] data_sw;
    logic              ack;
    logic              request;
    logic              valid;
    logic [DATA_W-1:0] data_out;
    logic              notice;
    logic              busy;
    logic              timeout;

    modport master (
        input  send, data_sw, ack,
        output request, valid, data_out, notice, busy, timeout
    );

    modport slave (
        input  request, valid, data_out,
        output ack
    );

endinterface

// File: rtl/master_timer.sv
// master_timer: saturating up-counter for the master control FSM.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - clears the count to 0 (counting resumes on the following cycles)
//   terminal  - count value at which done is raised
//   count     - current count; sticks at all-ones instead of wrapping
//   done      - high while count equals terminal
module master_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            count_q <= '0;
        end else if (count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign done  = (count_q == terminal);

endmodule

// File: rtl/master_control.sv
// master_control: master-side control FSM of the chip2chip link.
// On an accepted send pulse it captures data_sw, raises request until the slave acks,
// lights notice for DELAY_CYCLES, then presents the captured data with valid for
// VALID_CYCLES. Without an ack within TIMEOUT_CYCLES it aborts and sets sticky timeout.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - master_control_if.master (send, data_sw, ack in; request, valid, data_out,
//          notice, busy, timeout out). All outputs are registered.
// Build option: define ACK_SYNC_EN to pass ack through a 2-flop synchronizer
// (adds 2 cycles of ack-to-DELAY latency); otherwise both boards must share clk.
module master_control
    import master_control_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES   = DEFAULT_DELAY_CYCLES,
    parameter int unsigned VALID_CYCLES   = DEFAULT_VALID_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic              clk,
    input logic              rst,
    master_control_if.master bus
);

    localparam int unsigned TW = timer_width(DELAY_CYCLES, VALID_CYCLES, TIMEOUT_CYCLES);

    // The timer counts from 0, so a window of N cycles ends when count reaches N-1.
    localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LAST_DELAY = TW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0] LAST_VALID = TW'(VALID_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_lat_q, data_lat_d;
    logic              timeout_q, timeout_d;
    logic              request_q, request_d;
    logic              valid_q, valid_d;
    logic              notice_q, notice_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              ack_fsm;
    logic              timer_start;
    logic              timer_done;
    logic [TW-1:0]     timer_terminal;
    logic [TW-1:0]     timer_count;

`ifdef ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync_q <= 2'b00;
        end else begin
            ack_sync_q <= {ack_sync_q[0], bus.ack};
        end
    end

    assign ack_fsm = ack_sync_q[1];
`else
    assign ack_fsm = bus.ack;
`endif

    master_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (timer_start),
        .terminal (timer_terminal),
        .count    (timer_count),
        .done     (timer_done)
    );

    // Terminal value for the window owned by the current state.
    always_comb begin
        timer_terminal = '1;
        unique case (state_q)
            StWaitAck: timer_terminal = LAST_WAIT;
            StDelay:   timer_terminal = LAST_DELAY;
            StSend:    timer_terminal = LAST_VALID;
            default:   timer_terminal = '1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        data_lat_d  = data_lat_q;
        timeout_d   = timeout_q;
        timer_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.send) begin
                    state_d     = StWaitAck;
                    data_lat_d  = bus.data_sw;
                    timeout_d   = 1'b0;
                    timer_start = 1'b1;
                end
            end
            StWaitAck: begin
                // ack takes priority over a timeout expiring on the same cycle.
                if (ack_fsm) begin
                    state_d     = StDelay;
                    timer_start = 1'b1;
                end else if (timer_done) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StDelay: begin
                if (timer_done) begin
                    state_d     = StSend;
                    timer_start = 1'b1;
                end
            end
            StSend: begin
                if (timer_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register on the transition edge.
        request_d  = (state_d == StWaitAck);
        notice_d   = (state_d == StDelay);
        valid_d    = (state_d == StSend);
        busy_d     = (state_d != StIdle);
        data_out_d = (state_d == StSend) ? data_lat_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            data_lat_q <= '0;
            timeout_q  <= 1'b0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            notice_q   <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            data_lat_q <= data_lat_d;
            timeout_q  <= timeout_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            notice_q   <= notice_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.request  = request_q;
    assign bus.valid    = valid_q;
    assign bus.notice   = notice_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_master_control.sv
// tb_master_control: directed self-checking bench for master_control with
// DELAY_CYCLES=10, VALID_CYCLES=4, TIMEOUT_CYCLES=50. Honours ACK_SYNC_EN for ack latency.
module tb_master_control;

    localparam int unsigned DLY = 10;
    localparam int unsigned VLD = 4;
    localparam int unsigned TMO = 50;
`ifdef ACK_SYNC_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    master_control_if bus ();

    master_control #(
        .DELAY_CYCLES   (DLY),
        .VALID_CYCLES   (VLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle send pulse; returns just after the edge that sampled it.
    task automatic do_send(input logic [2:0] d);
        bus.data_sw = d;
        bus.send    = 1'b1;
        tick();
        bus.send    = 1'b0;
    endtask

    // One-cycle ack pulse; returns once the FSM has reacted (DELAY visible).
    task automatic pulse_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        for (int i = 0; i < ACK_LAT - 1; i++) tick();
    endtask

    // Measures the notice and valid windows from the first DELAY cycle.
    task automatic run_windows(input logic [2:0] exp, input logic poke,
                               output int n_notice, output int n_valid, output int n_data_err);
        n_notice   = 0;
        n_valid    = 0;
        n_data_err = 0;
        while (bus.notice && n_notice < 100) begin
            bus.send = poke;
            n_notice++;
            tick();
        end
        while (bus.valid && n_valid < 100) begin
            bus.send = poke;
            if (bus.data_out !== exp) n_data_err++;
            n_valid++;
            tick();
        end
        bus.send = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({bus.request, bus.valid, bus.notice, bus.busy, bus.timeout, bus.data_out} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {bus.request, bus.valid, bus.notice, bus.busy, bus.timeout, bus.data_out});
        end
    endtask

    task automatic test_basic();
        int req_lo, lat, nn, nv, nd;
        do_send(3'b101);
        total++;
        if (bus.request !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_req_start got=%b%b want=11", bus.request, bus.busy);
        end
        req_lo = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.request !== 1'b1) req_lo++;
        end
        total++;
        if (req_lo != 0) begin
            bad++;
            $display("FAIL basic_req_hold got=%0d low cycles want=0", req_lo);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        lat = 1;
        while (!bus.notice && lat < 10) begin
            tick();
            lat++;
        end
        total++;
        if (lat != ACK_LAT) begin
            bad++;
            $display("FAIL ack_latency got=%0d want=%0d", lat, ACK_LAT);
        end
        total++;
        if (bus.request !== 1'b0) begin
            bad++;
            $display("FAIL basic_req_drop got=%b want=0", bus.request);
        end
        run_windows(3'b101, 1'b0, nn, nv, nd);
        total++;
        if (nn != DLY) begin
            bad++;
            $display("FAIL basic_notice_len got=%0d want=%0d", nn, DLY);
        end
        total++;
        if (nv != VLD || nd != 0) begin
            bad++;
            $display("FAIL basic_valid got=%0d/%0d errs want=%0d/0", nv, nd, VLD);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.data_out !== 3'b000 || bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got=%b%b%b want=000", bus.busy, bus.valid, bus.data_out);
        end
    endtask

    task automatic test_capture();
        int nn, nv, nd;
        do_send(3'b011);
        tick();
        bus.data_sw = 3'b110;
        repeat (3) tick();
        pulse_ack();
        run_windows(3'b011, 1'b0, nn, nv, nd);
        total++;
        if (nv != VLD || nd != 0) begin
            bad++;
            $display("FAIL capture_data got=%0d valid %0d errs want=%0d valid 0 errs", nv, nd, VLD);
        end
    endtask

    task automatic test_timeout();
        int r, nn, nv, nd;
        do_send(3'b111);
        r = 0;
        while (bus.request && r < 200) begin
            r++;
            tick();
        end
        total++;
        if (r != TMO) begin
            bad++;
            $display("FAIL timeout_req_len got=%0d want=%0d", r, TMO);
        end
        total++;
        if (bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flag got=%b%b want=10", bus.timeout, bus.busy);
        end
        repeat (3) tick();
        total++;
        if (bus.timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b want=1", bus.timeout);
        end
        do_send(3'b010);
        total++;
        if (bus.timeout !== 1'b0 || bus.request !== 1'b1) begin
            bad++;
            $display("FAIL timeout_clear got=%b%b want=01", bus.timeout, bus.request);
        end
        repeat (2) tick();
        pulse_ack();
        run_windows(3'b010, 1'b0, nn, nv, nd);
        total++;
        if (nn != DLY || nv != VLD || nd != 0) begin
            bad++;
            $display("FAIL timeout_recover got=%0d/%0d/%0d want=%0d/%0d/0", nn, nv, nd, DLY, VLD);
        end
    endtask

    task automatic test_ignore_send();
        int nn, nv, nd, extra;
        do_send(3'b100);
        bus.data_sw = 3'b001;
        bus.send    = 1'b1;
        repeat (2) tick();
        bus.send    = 1'b0;
        tick();
        pulse_ack();
        run_windows(3'b100, 1'b1, nn, nv, nd);
        total++;
        if (nn != DLY || nv != VLD || nd != 0) begin
            bad++;
            $display("FAIL ignore_windows got=%0d/%0d/%0d want=%0d/%0d/0", nn, nv, nd, DLY, VLD);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid || bus.busy) extra++;
            tick();
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL ignore_no_requeue got=%0d busy cycles want=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int nn, nv, nd;
        do_send(3'b001);
        tick();
        pulse_ack();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus.request, bus.valid, bus.notice, bus.busy, bus.timeout, bus.data_out} !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b want=00000000",
                     {bus.request, bus.valid, bus.notice, bus.busy, bus.timeout, bus.data_out});
        end
        tick();
        total++;
        if (bus.notice !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_stays_idle got=%b%b want=00", bus.notice, bus.busy);
        end
        do_send(3'b110);
        tick();
        pulse_ack();
        run_windows(3'b110, 1'b0, nn, nv, nd);
        total++;
        if (nn != DLY || nv != VLD || nd != 0) begin
            bad++;
            $display("FAIL rst_mid_recover got=%0d/%0d/%0d want=%0d/%0d/0", nn, nv, nd, DLY, VLD);
        end
    endtask

    task automatic test_ack_at_expiry();
        int nn, nv, nd;
        do_send(3'b101);
        // FSM must see ack on the last WAIT_ACK cycle (timer count TMO-1).
        for (int i = 0; i < TMO - 1 - (ACK_LAT - 1); i++) tick();
        total++;
        if (bus.request !== 1'b1) begin
            bad++;
            $display("FAIL race_req_before got=%b want=1", bus.request);
        end
        pulse_ack();
        total++;
        if (bus.notice !== 1'b1 || bus.timeout !== 1'b0 || bus.request !== 1'b0) begin
            bad++;
            $display("FAIL race_ack_wins got=notice%b timeout%b req%b want=notice1 timeout0 req0",
                     bus.notice, bus.timeout, bus.request);
        end
        run_windows(3'b101, 1'b0, nn, nv, nd);
        total++;
        if (nn != DLY || nv != VLD || nd != 0 || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL race_complete got=%0d/%0d/%0d to=%b want=%0d/%0d/0 to=0",
                     nn, nv, nd, bus.timeout, DLY, VLD);
        end
    endtask

    initial begin
        bus.send    = 1'b0;
        bus.ack     = 1'b0;
        bus.data_sw = 3'b000;
        test_reset();
        test_basic();
        test_capture();
        test_timeout();
        test_ignore_send();
        test_reset_mid();
        test_ack_at_expiry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/master_control.md
Name: master_control

Overview:
- Master-side control FSM of the chip2chip link; directly upstream of the slave receiver.
- On a user send pulse it:
  - captures the 3-bit switch value;
  - raises request and waits for the slave's one-cycle ack;
  - lights notice for a fixed delay;
  - drives the captured data with valid held for a fixed window.
- Sits between the debounce/one-pulse front end and the inter-board pins.

Parameters:
- DELAY_CYCLES, 100_000_000: clocks in the post-ack notice delay (1 s at 100 MHz).
- VALID_CYCLES, 4: clocks for which valid and data_out are held.
- TIMEOUT_CYCLES, 300_000_000: clocks to wait for ack before abort (3 s).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- send  in  1  one-cycle pulse from the one-pulse stage; starts a transfer.
- data_sw  in  3  switch value to transmit; sampled only on an accepted send.
- ack  in  1  from slave; high for one cycle when the slave is ready for data.
- request  out  1  to slave; transfer request.
- valid  out  1  to slave; data_out is valid.
- data_out  out  3  to slave; transmitted value.
- notice  out  1  LED; high during the post-ack delay.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky error flag; set on ack timeout, cleared by the next accepted send or by rst.

Behaviour:
- All outputs are registered.
- Reset (rst high at a clk edge): state=IDLE; request=0, valid=0, notice=0, busy=0, timeout=0, data_out=0, captured data=0, timer cleared.
- Reset mid-transfer aborts immediately; no output glitches beyond that edge.
- FSM states and transitions:
  - IDLE:
    - on send=1: latch data_sw; clear timeout; start timer; go to WAIT_ACK.
    - request, busy and the other outputs reach their WAIT_ACK values on the edge after the send edge (1-cycle latency).
  - WAIT_ACK:
    - request=1, busy=1.
    - If ack=1: go to DELAY; request=0 from the next cycle; timer restarts.
    - Else if TIMEOUT_CYCLES have elapsed: go to IDLE; request=0; timeout=1.
    - If ack arrives on the same cycle as the timeout expiry, ack wins.
  - DELAY:
    - notice=1 for exactly DELAY_CYCLES cycles; ack is ignored.
    - Then notice=0, timer restarts, go to SEND.
  - SEND:
    - valid=1 and data_out=latched data for exactly VALID_CYCLES cycles.
    - Then valid=0 and data_out=0 on the same edge; go to IDLE.
- send is ignored while busy=1; it is not queued.
- data_sw changes after capture do not affect data_out.
- Timer: width clog2 of the largest of the three cycle parameters; never wraps; a start request clears it to 0.
- Spurious ack in IDLE, DELAY or SEND: ignored.

Optional Feature:
- Macro: ACK_SYNC_EN.
- Defined: ack passes through a 2-flop synchronizer before the FSM, for boards on unrelated clocks. The ack-to-DELAY response grows by 2 cycles.
- Undefined: ack is used directly; ack-to-DELAY is 1 cycle. The board-to-board link must share clk in this case.

Decomposition:
- Shared chip2chip package holds:
  - state encodings IDLE=2'b00, WAIT_ACK=2'b01, DELAY=2'b10, SEND=2'b11;
  - data width constant DATA_W=3;
  - default DELAY_CYCLES and VALID_CYCLES, so the master and slave agree.
- One sub-module, master_timer:
  - inputs: clk, rst, start (clear and run).
  - outputs: count, plus a done pulse at a programmable terminal value.
  - The FSM selects the terminal value per state.

Test Plan:
Run the bench with DELAY_CYCLES=10, VALID_CYCLES=4, TIMEOUT_CYCLES=50.
1. Reset, then data_sw=3'b101 and send pulse; ack pulse 7 cycles later:
   - request high from cycle 1 until the ack edge;
   - notice high for exactly 10 cycles;
   - valid high for 4 cycles with data_out=101;
   - busy low afterwards.
2. Capture isolation: send with data_sw=3'b011, then change data_sw to 3'b110 before ack -> data_out=011 during SEND.
3. No ack:
   - request drops after 50 cycles; timeout=1; state IDLE.
   - A following send clears timeout and completes normally with ack.
4. Send pulses in WAIT_ACK, DELAY and SEND -> ignored; exactly one valid window per transfer.
5. rst asserted for one cycle during DELAY -> all outputs 0 next cycle, then a clean transfer on the next send.
6. ack asserted on the same cycle the timeout expires -> DELAY entered; timeout stays 0. With ACK_SYNC_EN defined, ack-to-notice latency is 3 cycles (1 cycle without).
